branch_target_execute: RTL and testbench
========================================

# branch_target_execute

Execute-stage branch unit for the MIPS pipeline: computes the branch target from the incremented PC and the sign-extended immediate, resolves the branch condition, and registers the result. When a taken branch is resolved, it issues a one-cycle redirect to instruction fetch. A small FSM then squashes the configured number of younger instructions. It replaces the combinational target adder with a parametrised, pipelined, stall/flush-aware block.

## Interface
- `len`, 32: datapath width (PC, immediate, operands).
- `shift`, 2: left shift applied to the immediate before the add (word alignment).
- `squash_cycles`, 1: younger instructions to squash after a taken branch; range 0..7.
- `i_clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_valid` in 1: the execute-stage instruction is valid.
- `i_stall` in 1: hold all registered state and outputs.
- `i_flush` in 1: kill the in-flight branch; return to IDLE.
- `i_branch_op` in 3: branch condition code, encoded in the package.
- `i_pc` in len: PC+4 of the branch.
- `i_imm` in len: sign-extended immediate.
- `i_rs_data` in len: rs operand.
- `i_rt_data` in len: rt operand.
- `o_valid` out 1: registered result is valid.
- `o_target` out len: registered branch target.
- `o_taken` out 1: registered condition outcome.
- `o_redirect` out 1: one-cycle pulse telling fetch to load `o_target`.
- `o_squash` out 1: instruction now entering ID/EX must be killed.

## Operation
- Target arithmetic:
  - `target = i_pc + (i_imm << shift)`, truncated to len bits.
  - Carry is discarded; wrap past 2^len is legal.
- Condition evaluation (ops from the package):
  - NONE=0: never taken.
  - BEQ=1: taken when rs == rt.
  - BNE=2: taken when rs != rt.
  - BLEZ=3: signed rs <= 0.
  - BGTZ=4: signed rs > 0.
  - BLTZ=5: signed rs < 0.
  - BGEZ=6: signed rs >= 0.
  - 7 is reserved and treated as NONE.
- FSM states:
  - IDLE: accepts an instruction when i_valid and not i_stall. On a taken result, go to REDIRECT.
  - REDIRECT: lasts one cycle with o_redirect=1. Go to SQUASH if squash_cycles>0, otherwise go to IDLE.
  - SQUASH: counter loads squash_cycles and decrements each unstalled cycle. o_squash=1. i_valid is ignored, so squashed branches never resolve. Exit to IDLE when the count reaches 1.
- Not-taken or NONE results update `o_valid`/`o_target`/`o_taken` without redirecting.
- Precedence: `i_flush` > `i_stall` > normal.
  - Flush clears o_valid, o_taken, o_redirect, o_squash and the counter, and forces IDLE.
- A stall in REDIRECT holds o_redirect high until the stall releases. Fetch acts only on the unstalled cycle.

## Timing
- Reset values (all outputs are 0):
  - o_valid=0, o_target=0, o_taken=0, o_redirect=0, o_squash=0.
  - FSM=IDLE, counter=0.
- Latency: inputs sampled at edge N appear on outputs after edge N; o_redirect is high during cycle N+1.
- o_squash is high for exactly squash_cycles unstalled cycles, starting the cycle after o_redirect.
- Reset asserted mid-SQUASH aborts immediately and asynchronously, with no residual pulse.
- Back-to-back branches: the second branch arrives during REDIRECT/SQUASH and is discarded. It is wrong-path by construction.

## Configuration
- `BRANCH_STATS_EN` defined adds two outputs, each len wide:
  - `o_br_count`: number of accepted non-NONE branches.
  - `o_taken_count`: number of accepted taken branches.
  - Both counters wrap, reset to 0, hold on stall, and are unaffected by flush.
- Without the macro, the ports and counters are absent.

## Structure
- The package `branch_pkg` holds:
  - branch op localparams (NONE..BGEZ, 3 bits);
  - FSM state encoding (IDLE, REDIRECT, SQUASH);
  - the squash counter width (3).
- The sub-module `branch_cond_eval` is combinational. It maps op, rs and rt to taken, so it can be reused by the decode-stage early-branch path.

## Test plan
- BEQ, pc=0x00000100, imm=0x00000004, rs=rt=5 -> next cycle o_valid=1, o_taken=1, o_target=0x00000110, o_redirect=1 for 1 cycle, then o_squash=1 for 1 cycle.
- BNE, rs=rt=7, imm=0xFFFFFFFF, pc=0x00000100 -> o_taken=0, o_target=0x000000FC, no redirect, no squash.
- BLTZ rs=0x80000000 and BGTZ rs=0x80000000 -> taken=1 and taken=0 respectively (signed compare).
- pc=0xFFFFFFF0, imm=0x00000008 -> o_target=0x00000010 (wrap).
- squash_cycles=3, taken BEQ with i_stall held 2 cycles during SQUASH -> o_squash high 5 cycles total. A valid BEQ presented during SQUASH produces no second redirect.
- Taken branch with i_flush in the same cycle as REDIRECT -> o_redirect and o_squash drop next cycle, FSM returns to IDLE. With BRANCH_STATS_EN, the counts still reflect the accepted branch.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch unit: branch condition
// codes, FSM state encoding and squash counter width.
package branch_pkg;

  // Branch condition codes; 3'd7 is reserved and behaves as BR_NONE.
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;
  localparam logic [2:0] BR_RSVD = 3'd7;

  // Squash counter holds 0..7 younger instructions.
  localparam int SQ_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } br_state_e;

  // True for a real conditional branch (not NONE, not reserved).
  function automatic logic is_branch(input logic [2:0] op);
    return (op != BR_NONE) && (op != BR_RSVD);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator. Kept standalone so the
// decode-stage early-branch path can reuse the same op decoding.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int len = 32
) (
  input  logic [2:0]     op,
  input  logic [len-1:0] rs,
  input  logic [len-1:0] rt,
  output logic           taken
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs[len-1];
  assign rs_zero = (rs == '0);

  // Signed compares against zero reduce to sign bit and zero detect.
  always_comb begin
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = (rs == rt);
      BR_BNE:  taken = (rs != rt);
      BR_BLEZ: taken = rs_neg | rs_zero;
      BR_BGTZ: taken = ~rs_neg & ~rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = ~rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_target_execute.sv
// Execute-stage branch unit: computes the branch target, resolves the
// condition, registers the result, pulses a redirect to fetch on a taken
// branch and then squashes squash_cycles younger instructions.
// Optional feature macro: BRANCH_STATS_EN adds branch / taken counters.
module branch_target_execute
  import branch_pkg::*;
#(
  parameter int len           = 32,
  parameter int shift         = 2,
  parameter int squash_cycles = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  input  logic           i_stall,
  input  logic           i_flush,
  input  logic [2:0]     i_branch_op,
  input  logic [len-1:0] i_pc,
  input  logic [len-1:0] i_imm,
  input  logic [len-1:0] i_rs_data,
  input  logic [len-1:0] i_rt_data,
  output logic           o_valid,
  output logic [len-1:0] o_target,
  output logic           o_taken,
  output logic           o_redirect,
  output logic           o_squash
`ifdef BRANCH_STATS_EN
  ,
  output logic [len-1:0] o_br_count,
  output logic [len-1:0] o_taken_count
`endif
);

  localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(squash_cycles);

  logic [len-1:0]      imm_sh;
  logic [len-1:0]      target;
  logic                cond_taken;
  br_state_e           state;
  logic [SQ_CNT_W-1:0] sq_cnt;

  // Word-aligned offset; carry out of the add is dropped so wrap is legal.
  assign imm_sh = i_imm << shift;
  assign target = i_pc + imm_sh;

  branch_cond_eval #(.len(len)) u_cond (
    .op    (i_branch_op),
    .rs    (i_rs_data),
    .rt    (i_rt_data),
    .taken (cond_taken)
  );

  // Resolve / redirect / squash sequencer with registered outputs.
  // Flush beats stall beats normal operation; stall freezes everything,
  // which also stretches o_redirect until fetch sees an unstalled cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      sq_cnt     <= '0;
      o_valid    <= 1'b0;
      o_target   <= '0;
      o_taken    <= 1'b0;
      o_redirect <= 1'b0;
      o_squash   <= 1'b0;
    end else if (i_flush) begin
      state      <= ST_IDLE;
      sq_cnt     <= '0;
      o_valid    <= 1'b0;
      o_taken    <= 1'b0;
      o_redirect <= 1'b0;
      o_squash   <= 1'b0;
    end else if (!i_stall) begin
      case (state)
        ST_IDLE: begin
          o_valid    <= i_valid;
          o_redirect <= i_valid & cond_taken;
          if (i_valid) begin
            o_target <= target;
            o_taken  <= cond_taken;
            if (cond_taken) state <= ST_REDIRECT;
          end
        end
        // Anything arriving here is wrong-path and is dropped.
        ST_REDIRECT: begin
          o_valid    <= 1'b0;
          o_redirect <= 1'b0;
          if (squash_cycles > 0) begin
            state    <= ST_SQUASH;
            o_squash <= 1'b1;
            sq_cnt   <= SQ_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SQUASH: begin
          o_valid <= 1'b0;
          if (sq_cnt <= SQ_CNT_W'(1)) begin
            state    <= ST_IDLE;
            o_squash <= 1'b0;
            sq_cnt   <= '0;
          end else begin
            sq_cnt <= sq_cnt - 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          sq_cnt     <= '0;
          o_valid    <= 1'b0;
          o_redirect <= 1'b0;
          o_squash   <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic accept;

  // Only instructions actually resolved in IDLE are counted.
  assign accept = (state == ST_IDLE) && i_valid && !i_stall && !i_flush;

  // Free-running wrap counters; flush does not touch them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_count    <= '0;
      o_taken_count <= '0;
    end else if (accept) begin
      if (is_branch(i_branch_op)) o_br_count    <= o_br_count + 1'b1;
      if (cond_taken)             o_taken_count <= o_taken_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_execute.sv
// Bench for branch_target_execute: two instances (squash 1 and squash 3)
// share stimulus; each is compared every cycle against its own
// cycle-level reference model built from the branch rules.
module tb_branch_target_execute;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] pc = '0, imm = '0, rs = '0, rt = '0;

  logic        ov[2], otk[2], ord[2], osq[2];
  logic [31:0] ot[2];
`ifdef BRANCH_STATS_EN
  logic [31:0] obr[2], otc[2];
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int          sqc[2];
  logic        m_valid[2], m_taken[2], m_redir[2], m_sq[2];
  logic [31:0] m_target[2], m_br[2], m_tk[2];
  int          sq_left[2];

  logic [35:0] obs[2], expv[2];

  always #5 clk = ~clk;

  branch_target_execute #(.len(32), .shift(2), .squash_cycles(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_branch_op(op), .i_pc(pc), .i_imm(imm), .i_rs_data(rs), .i_rt_data(rt),
    .o_valid(ov[0]), .o_target(ot[0]), .o_taken(otk[0]), .o_redirect(ord[0]), .o_squash(osq[0])
`ifdef BRANCH_STATS_EN
    , .o_br_count(obr[0]), .o_taken_count(otc[0])
`endif
  );

  branch_target_execute #(.len(32), .shift(2), .squash_cycles(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_branch_op(op), .i_pc(pc), .i_imm(imm), .i_rs_data(rs), .i_rt_data(rt),
    .o_valid(ov[1]), .o_target(ot[1]), .o_taken(otk[1]), .o_redirect(ord[1]), .o_squash(osq[1])
`ifdef BRANCH_STATS_EN
    , .o_br_count(obr[1]), .o_taken_count(otc[1])
`endif
  );

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      obs[k]  = {ov[k], ot[k], otk[k], ord[k], osq[k]};
      expv[k] = {m_valid[k], m_target[k], m_taken[k], m_redir[k], m_sq[k]};
    end
  end

  function automatic logic ref_taken(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    sa = a;
    case (o)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return sa <= 0;
      3'd4: return sa > 0;
      3'd5: return sa < 0;
      3'd6: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_taken[k] = 0; m_redir[k] = 0; m_sq[k] = 0;
      m_target[k] = '0; m_br[k] = '0; m_tk[k] = '0; sq_left[k] = 0;
    end
  endtask

  // One clock: advance the model with the inputs seen at this edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        m_valid[k] = 0; m_taken[k] = 0; m_redir[k] = 0; m_sq[k] = 0; sq_left[k] = 0;
      end else if (stall) begin
        // everything holds
      end else if (m_redir[k]) begin
        m_redir[k] = 0; m_valid[k] = 0; m_sq[k] = 1; sq_left[k] = sqc[k];
      end else if (m_sq[k]) begin
        m_valid[k] = 0;
        sq_left[k]--;
        if (sq_left[k] == 0) m_sq[k] = 0;
      end else begin
        m_valid[k] = valid;
        m_redir[k] = 0;
        if (valid) begin
          m_target[k] = pc + (imm << 2);
          m_taken[k]  = ref_taken(op, rs, rt);
          m_redir[k]  = m_taken[k];
          if (op != 3'd0 && op != 3'd7) m_br[k] = m_br[k] + 1;
          if (m_taken[k]) m_tk[k] = m_tk[k] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    valid = 0; stall = 0; flush = 0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; valid = 0; stall = 0; flush = 0;
    model_clear();
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 36'd0) begin
        errors++; $display("FAIL reset_out dut%0d: got %h want 0", k, obs[k]);
      end
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_beq_taken();
    idle(5);
    valid = 1; op = 3'd1; pc = 32'h100; imm = 32'h4; rs = 32'd5; rt = 32'd5;
    tick();
    valid = 0;
    checks++;
    if ({ov[0], otk[0], ord[0], osq[0]} !== 4'b1110 || ot[0] !== 32'h110) begin
      errors++; $display("FAIL beq_resolve: got v%b t%b r%b s%b tgt %h want v1 t1 r1 s0 tgt 00000110",
                         ov[0], otk[0], ord[0], osq[0], ot[0]);
    end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++; $display("FAIL beq_model dut%0d cyc%0d: got %h want %h", k, c, obs[k], expv[k]);
        end
      end
      if (c == 1) begin
        checks++;
        if (ord[0] !== 1'b0 || osq[0] !== 1'b1) begin
          errors++; $display("FAIL beq_squash: got r%b s%b want r0 s1", ord[0], osq[0]);
        end
      end
      if (c == 2) begin
        checks++;
        if (osq[0] !== 1'b0) begin
          errors++; $display("FAIL beq_squash_end: got s%b want s0", osq[0]);
        end
      end
    end
  endtask

  task automatic test_bne_not_taken();
    idle(5);
    valid = 1; op = 3'd2; pc = 32'h100; imm = 32'hFFFF_FFFF; rs = 32'd7; rt = 32'd7;
    tick();
    valid = 0;
    checks++;
    if (ov[0] !== 1'b1 || otk[0] !== 1'b0 || ot[0] !== 32'hFC || ord[0] !== 1'b0) begin
      errors++; $display("FAIL bne: got v%b t%b r%b tgt %h want v1 t0 r0 tgt 000000fc",
                         ov[0], otk[0], ord[0], ot[0]);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ord[k] !== 1'b0 || osq[k] !== 1'b0 || obs[k] !== expv[k]) begin
        errors++; $display("FAIL bne_quiet dut%0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_signed();
    idle(5);
    valid = 1; op = 3'd5; rs = 32'h8000_0000; rt = 0; pc = 32'h200; imm = 0;
    tick(); valid = 0;
    checks++;
    if (otk[0] !== 1'b1) begin
      errors++; $display("FAIL bltz_signed: got %b want 1", otk[0]);
    end
    idle(5);
    valid = 1; op = 3'd4;
    tick(); valid = 0;
    checks++;
    if (otk[0] !== 1'b0 || ov[0] !== 1'b1) begin
      errors++; $display("FAIL bgtz_signed: got t%b v%b want t0 v1", otk[0], ov[0]);
    end
  endtask

  task automatic test_wrap();
    idle(5);
    valid = 1; op = 3'd1; pc = 32'hFFFF_FFF0; imm = 32'h8; rs = 1; rt = 2;
    tick(); valid = 0;
    checks++;
    if (ot[0] !== 32'h10 || ot[1] !== 32'h10) begin
      errors++; $display("FAIL wrap: got %h / %h want 00000010", ot[0], ot[1]);
    end
  endtask

  task automatic test_squash_stall();
    int sq_hi = 0;
    int redirs = 0;
    idle(5);
    valid = 1; op = 3'd1; pc = 32'h40; imm = 32'h10; rs = 9; rt = 9;
    tick();
    checks++;
    if (ord[1] !== 1'b1) begin
      errors++; $display("FAIL sq3_redirect: got %b want 1", ord[1]);
    end
    for (int i = 0; i < 8; i++) begin
      valid = (i >= 1 && i <= 4);
      stall = (i == 2 || i == 3);
      tick();
      if (osq[1] === 1'b1) sq_hi++;
      if (ord[1] === 1'b1) redirs++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++; $display("FAIL sq3_model dut%0d i%0d: got %h want %h", k, i, obs[k], expv[k]);
        end
      end
    end
    valid = 0; stall = 0;
    checks++;
    if (sq_hi !== 5) begin
      errors++; $display("FAIL sq3_len: got %0d cycles want 5", sq_hi);
    end
    checks++;
    if (redirs !== 0) begin
      errors++; $display("FAIL sq3_second_redirect: got %0d want 0", redirs);
    end
  endtask

  task automatic test_flush();
    idle(5);
    valid = 1; op = 3'd1; pc = 32'h300; imm = 32'h1; rs = 3; rt = 3;
    tick();
    valid = 0; flush = 1;
    tick();
    flush = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ord[k] !== 1'b0 || osq[k] !== 1'b0 || ov[k] !== 1'b0 || otk[k] !== 1'b0 || obs[k] !== expv[k]) begin
        errors++; $display("FAIL flush dut%0d: got %h want %h", k, obs[k], expv[k]);
      end
`ifdef BRANCH_STATS_EN
      checks++;
      if (obr[k] !== m_br[k] || otc[k] !== m_tk[k]) begin
        errors++; $display("FAIL flush_stats dut%0d: got %0d/%0d want %0d/%0d", k, obr[k], otc[k], m_br[k], m_tk[k]);
      end
`endif
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin
        errors++; $display("FAIL flush_idle dut%0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    idle(5);
    valid = 1; op = 3'd2; pc = 32'h80; imm = 32'h2; rs = 1; rt = 4;
    tick(); valid = 0;
    tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if (osq[1] !== 1'b0 || obs[1] !== 36'd0) begin
      errors++; $display("FAIL async_reset: got %h want 0", obs[1]);
    end
    model_clear();
    @(negedge clk); rst_n = 1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin
        errors++; $display("FAIL post_reset dut%0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pick;
    for (int n = 0; n < 400; n++) begin
      valid = ($urandom_range(0, 99) < 60);
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 5);
      op    = 3'($urandom_range(0, 7));
      pc    = $urandom;
      imm   = $urandom;
      case ($urandom_range(0, 4))
        0: pick = 32'd0;
        1: pick = 32'h8000_0000;
        2: pick = 32'hFFFF_FFFF;
        3: pick = 32'd1;
        default: pick = $urandom;
      endcase
      rs = pick;
      rt = ($urandom_range(0, 1) == 1) ? pick : $urandom;
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv[k]) begin
          errors++; $display("FAIL random dut%0d n%0d: got %h want %h", k, n, obs[k], expv[k]);
        end
`ifdef BRANCH_STATS_EN
        checks++;
        if (obr[k] !== m_br[k] || otc[k] !== m_tk[k]) begin
          errors++; $display("FAIL random_stats dut%0d n%0d: got %0d/%0d want %0d/%0d", k, n, obr[k], otc[k], m_br[k], m_tk[k]);
        end
`endif
      end
    end
    valid = 0; stall = 0; flush = 0;
  endtask

  initial begin
    sqc[0] = 1;
    sqc[1] = 3;
    model_clear();
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_signed();
    test_wrap();
    test_squash_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
